// File: rtl/spi_periph.sv
// SPI peripheral front end: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
// Pins are synchronised into clk, MOSI is deserialised into rx_byte with a
// one-clk new_data pulse, and tx_byte is serialised on MISO in the next slot.
module spi_periph #(
  parameter int SYNC_STAGES = 2  // flops per pin synchroniser, 2..4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       new_data,
  output logic [7:0] rx_byte,
  input  logic [7:0] tx_byte,
  output logic       active
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       new_data_q, new_data_d;
  logic       active_q, active_d;
  logic       miso_q, miso_d;

  logic s_sclk, s_cs_n, s_mosi;
  logic rise, fall;

  assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign s_cs_n = cs_n_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

  // Edges are detected on the synchronised clock, so they are one clk wide.
  assign rise = s_sclk & ~sclk_prev_q;
  assign fall = ~s_sclk & sclk_prev_q;

  // Synchroniser chains shift the raw pins in; sclk history feeds edge detect.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = s_sclk;
  end

  // State register plus every datapath flop, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_n_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rx_byte_q   <= 8'h00;
      new_data_q  <= 1'b0;
      active_q    <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_n_sync_q <= cs_n_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      new_data_q  <= new_data_d;
      active_q    <= active_d;
      miso_q      <= miso_d;
    end
  end

  // Next state: chip select alone decides frame entry and exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!s_cs_n) state_d = SHIFT;
      SHIFT: if (s_cs_n)  state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs: shift on edges, load at byte boundaries.
  always_comb begin
    // NOTE: hold-value defaults first, so no path through this block infers a latch.
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    rx_byte_d  = rx_byte_q;
    new_data_d = 1'b0;
    active_d   = active_q;
    unique case (state_q)
      IDLE: begin
        if (!s_cs_n) begin
          tx_shift_d = tx_byte;
          rx_shift_d = 8'h00;
          bit_cnt_d  = 3'd0;
          active_d   = 1'b1;
        end
      end
      SHIFT: begin
        if (s_cs_n) begin
          // Frame ended: any partial byte is dropped, rx_byte is untouched.
          bit_cnt_d = 3'd0;
          active_d  = 1'b0;
        end else if (rise) begin
          rx_shift_d = {rx_shift_q[6:0], s_mosi};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d  = {rx_shift_q[6:0], s_mosi};
            new_data_d = 1'b1;
          end
        end else if (fall) begin
          // Boundary fall picks up the controller's reply for the next slot.
          if (bit_cnt_q == 3'd0) tx_shift_d = tx_byte;
          else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
    endcase
    miso_d = (state_d == SHIFT) ? tx_shift_d[7] : 1'b0;
  end

  assign miso     = miso_q;
  assign new_data = new_data_q;
  assign rx_byte  = rx_byte_q;
  assign active   = active_q;

endmodule

// File: tb/tb_spi_periph.sv
// Self-checking bench for spi_periph: a bit-banged mode-0 host drives frames,
// and a byte-level reference (bytes sent, replies queued) predicts the outcome.
module tb_spi_periph;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_HALF    = SYNC_STAGES + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       new_data;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: bytes the host sends, replies the controller offers,
  // and what was observed during the frame.
  logic [7:0] mosi_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] got_q[$];
  logic [7:0] miso_got_q[$];
  int         pulses;
  bit         tx_load_pend;
  logic [7:0] last_rx;
  logic [7:0] m;

  spi_periph #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .new_data (new_data),
    .rx_byte  (rx_byte),
    .tx_byte  (tx_byte),
    .active   (active)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk: observe outputs just after the edge (acting as the controller),
  // then leave the pins free to be driven a little later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_load_pend) begin
      if (tx_q.size() > 0) tx_byte = tx_q.pop_front();
      tx_load_pend = 1'b0;
    end
    if (new_data) begin
      pulses++;
      got_q.push_back(rx_byte);
      tx_load_pend = 1'b1;
    end
    #1;
  endtask

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Mode-0 host: data set while sclk low, MISO sampled at the rising edge.
  task automatic spi_bits(input logic [7:0] d, input int nbits, input int half,
                          output logic [7:0] mo);
    mo = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      wait_clk(half);
      sclk = 1'b1;
      mo = {mo[6:0], miso};
      wait_clk(half);
      sclk = 1'b0;
    end
  endtask

  // Full frame of mosi_q bytes; tx_q holds the first reply plus one per byte.
  task automatic run_frame(input int half, input string tag);
    logic [7:0] mb;
    exp_tx_q = tx_q;
    got_q.delete();
    miso_got_q.delete();
    pulses = 0;
    tx_load_pend = 1'b0;
    tx_byte = tx_q.pop_front();
    cs_n = 1'b0;
    wait_clk(10);
    check({tag, " active_on"}, 32'(active), 32'd1);
    foreach (mosi_q[i]) begin
      spi_bits(mosi_q[i], 8, half, mb);
      miso_got_q.push_back(mb);
    end
    wait_clk(half);
    cs_n = 1'b1;
    wait_clk(10);
    check({tag, " active_off"}, 32'(active), 32'd0);
    check({tag, " miso_idle"}, 32'(miso), 32'd0);
    check({tag, " pulses"}, 32'(pulses), 32'(mosi_q.size()));
    foreach (mosi_q[i]) begin
      check($sformatf("%s rx[%0d]", tag, i),
            (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hxxxx_xxxx, {24'h0, mosi_q[i]});
      check($sformatf("%s miso[%0d]", tag, i), {24'h0, miso_got_q[i]}, {24'h0, exp_tx_q[i]});
    end
    if (mosi_q.size() > 0) last_rx = mosi_q[mosi_q.size()-1];
    check({tag, " rx_byte_final"}, {24'h0, rx_byte}, {24'h0, last_rx});
  endtask

  initial begin
    rst = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    tx_byte = 8'h00;
    last_rx = 8'h00;
    pulses = 0;
    tx_load_pend = 1'b0;

    // Reset values.
    wait_clk(4);
    check("rst miso", 32'(miso), 32'd0);
    check("rst new_data", 32'(new_data), 32'd0);
    check("rst rx_byte", {24'h0, rx_byte}, 32'h00);
    check("rst active", 32'(active), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Clocking with chip select high must not produce data.
    pulses = 0;
    for (int k = 0; k < 2; k++) spi_bits(8'($urandom), 8, MIN_HALF, m);
    wait_clk(10);
    check("idle pulses", 32'(pulses), 32'd0);
    check("idle active", 32'(active), 32'd0);
    check("idle rx_byte", {24'h0, rx_byte}, 32'h00);
    check("idle miso", 32'(miso), 32'd0);

    // Single byte A5 out, 07 back.
    mosi_q = '{8'hA5};
    tx_q   = '{8'h07};
    run_frame(8, "a5");

    // Two bytes in one frame; reply changes after the first byte.
    mosi_q = '{8'h83, 8'h00};
    tx_q   = '{8'h07, 8'h3C};
    run_frame(8, "two");

    // Non-zero byte so the abort test can see rx_byte being held.
    mosi_q = '{8'hC9};
    tx_q   = '{8'($urandom)};
    run_frame(MIN_HALF, "pre_abort");

    // Abort after 5 bits of FF.
    pulses = 0;
    tx_load_pend = 1'b0;
    tx_byte = 8'h00;
    cs_n = 1'b0;
    wait_clk(10);
    spi_bits(8'hFF, 5, 8, m);
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(10);
    check("abort pulses", 32'(pulses), 32'd0);
    check("abort rx_byte", {24'h0, rx_byte}, {24'h0, last_rx});
    check("abort active", 32'(active), 32'd0);

    mosi_q = '{8'h12};
    tx_q   = '{8'($urandom)};
    run_frame(8, "post_abort");

    // Reset in the middle of a byte.
    cs_n = 1'b0;
    wait_clk(10);
    spi_bits(8'($urandom), 4, 8, m);
    sclk = 1'b1;
    rst = 1'b1;
    tick();
    check("midrst miso", 32'(miso), 32'd0);
    check("midrst new_data", 32'(new_data), 32'd0);
    check("midrst rx_byte", {24'h0, rx_byte}, 32'h00);
    check("midrst active", 32'(active), 32'd0);
    sclk = 1'b0;
    cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    last_rx = 8'h00;
    wait_clk(6);

    mosi_q = '{8'h5A};
    tx_q   = '{8'($urandom)};
    run_frame(8, "post_rst");

    // 16 random bytes at the minimum sclk phase length.
    mosi_q.delete();
    tx_q.delete();
    for (int k = 0; k < 16; k++) mosi_q.push_back(8'($urandom));
    for (int k = 0; k < 17; k++) tx_q.push_back(8'($urandom));
    run_frame(MIN_HALF, "burst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
